// File: rtl/rtlmeter_cycle_window.sv
// Cycle-window measurement unit: counts cycles between start and stop markers and reports over valid/ready.
// Define RTLMETER_CYCLE_WINDOW_TIMEOUT_EN to build the budget watchdog (res_timeout_o, finish_req_o).
module rtlmeter_cycle_window #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] budget_i,
    output logic             busy_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [CNT_W-1:0] res_cycles_o,
    output logic             res_sat_o,
    output logic             res_timeout_o,
    output logic             finish_req_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic [CNT_W-1:0] r_res_cycles;
    logic             r_res_sat;

    logic             w_cnt_max;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_sat_next;

    // The counter holds at all-ones instead of wrapping; hitting that ceiling marks the window saturated.
    assign w_cnt_max  = &r_cnt;
    assign w_cnt_inc  = w_cnt_max ? r_cnt : (r_cnt + ONE);
    assign w_sat_next = r_sat | w_cnt_max;

`ifdef RTLMETER_CYCLE_WINDOW_TIMEOUT_EN
    logic [CNT_W-1:0] r_bud;
    logic             r_res_timeout;
    logic             r_finish;
    logic             w_budget_hit;

    assign w_budget_hit  = (r_bud != '0) && (w_cnt_inc == r_bud);
    assign res_timeout_o = r_res_timeout;
    assign finish_req_o  = r_finish;
`else
    logic w_unused_budget;

    assign w_unused_budget = ^budget_i;
    assign res_timeout_o   = 1'b0;
    assign finish_req_o    = 1'b0;
`endif

    assign busy_o       = (r_state == S_RUN);
    assign res_valid_o  = (r_state == S_REPORT);
    assign res_cycles_o = r_res_cycles;
    assign res_sat_o    = r_res_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_sat        <= 1'b0;
            r_res_cycles <= '0;
            r_res_sat    <= 1'b0;
`ifdef RTLMETER_CYCLE_WINDOW_TIMEOUT_EN
            r_bud         <= '0;
            r_res_timeout <= 1'b0;
            r_finish      <= 1'b0;
`endif
        end else begin
`ifdef RTLMETER_CYCLE_WINDOW_TIMEOUT_EN
            r_finish <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_sat   <= 1'b0;
`ifdef RTLMETER_CYCLE_WINDOW_TIMEOUT_EN
                        r_bud   <= budget_i;
`endif
                    end
                end
                S_RUN: begin
                    r_cnt <= w_cnt_inc;
                    r_sat <= w_sat_next;
                    // A stop arriving in the same cycle as the budget expiry takes priority.
                    if (stop_i) begin
                        r_state      <= S_REPORT;
                        r_res_cycles <= w_cnt_inc;
                        r_res_sat    <= w_sat_next;
`ifdef RTLMETER_CYCLE_WINDOW_TIMEOUT_EN
                        r_res_timeout <= 1'b0;
                    end else if (w_budget_hit) begin
                        r_state       <= S_REPORT;
                        r_res_cycles  <= r_bud;
                        r_res_sat     <= w_sat_next;
                        r_res_timeout <= 1'b1;
                        r_finish      <= 1'b1;
`endif
                    end
                end
                S_REPORT: begin
                    if (res_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rtlmeter_cycle_window.md
# rtlmeter_cycle_window

Synthesizable cycle-window measurement unit: the hardware-side counterpart to the benchmark cycle counter. It counts main-clock cycles between a DUT-driven start marker and stop marker, then hands the count to a consumer over a valid/ready handshake. It sits beside the top-level DUT on the main clock. The benchmark harness reads the result and uses the optional watchdog output to end runaway runs.

## Interface
- CNT_W, 64, width of the cycle counter and result (≥ 8)
- clk  in  1  main clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  single-cycle start marker from DUT
- stop_i  in  1  single-cycle stop marker from DUT
- budget_i  in  CNT_W  cycle budget, sampled on accepted start; 0 = unlimited
- busy_o  out  1  high in RUN
- res_valid_o  out  1  result available
- res_ready_i  in  1  consumer accepts result
- res_cycles_o  out  CNT_W  measured cycle count, stable while res_valid_o
- res_sat_o  out  1  counter saturated during window
- res_timeout_o  out  1  window ended by budget, not by stop_i
- finish_req_o  out  1  one-cycle pulse requesting end of simulation on timeout

## Operation
- FSM states: IDLE, RUN, REPORT.
- IDLE: start_i=1 → RUN; cnt←0, sat←0; budget_i latched into bud. stop_i is ignored in IDLE, including when asserted in the same cycle as start_i.
- RUN:
  - cnt←cnt+1 each cycle. At all-ones it holds and sets sat. It never wraps.
  - stop_i=1 → REPORT with res_cycles←cnt+1 (saturating) and res_timeout←0.
  - start_i in RUN is ignored; it does not restart the window.
- Result definition: start accepted in cycle T, stop in cycle T+N → res_cycles_o = N (N ≥ 1).
- REPORT:
  - res_valid_o=1 and the result is held.
  - res_valid_o & res_ready_i → IDLE; res_valid_o drops the next cycle.
  - start_i and stop_i are ignored in REPORT. A start in the handshake cycle is also ignored.
- res_cycles_o, res_sat_o and res_timeout_o retain their last values after the handshake, until the next REPORT entry.
- Arithmetic: every increment is CNT_W-bit with saturation. No value ever wraps to 0.

## Timing
- Reset values: state IDLE; busy_o, res_valid_o, res_sat_o, res_timeout_o and finish_req_o all 0; res_cycles_o 0.
- Reset asserted mid-RUN or mid-REPORT aborts immediately. Outputs take reset values the cycle after rst is sampled high, and the pending result is discarded.
- busy_o is high from cycle T+1 through the cycle in which stop is sampled.
- res_valid_o rises the cycle after stop is sampled (latency 1).
- Minimum window-to-window spacing: stop at S, handshake at S+1, new start accepted at S+2.

## Configuration
- Macro RTLMETER_CYCLE_WINDOW_TIMEOUT_EN enables the budget watchdog.
- Defined:
  - In RUN with bud≠0 and cnt+1==bud and stop_i=0: go to REPORT with res_cycles←bud and res_timeout←1.
  - finish_req_o pulses high for exactly one cycle, coincident with the first res_valid_o cycle.
  - If stop_i=1 in that same cycle, stop wins: res_timeout=0 and there is no finish pulse.
- Undefined: budget_i is ignored, no bud register is built, and res_timeout_o and finish_req_o are constant 0.

## Test plan
- Basic window: reset, start at cycle 10, stop at cycle 25, res_ready_i=1 → res_valid_o high at cycle 26 for 1 cycle, res_cycles_o=15, res_sat_o=0, res_timeout_o=0.
- Backpressure and ignored markers:
  - Stop with res_ready_i=0 for 5 cycles, then 1 → res_valid_o held 6 cycles and res_cycles_o stable.
  - start_i pulses during REPORT produce no new window (busy_o stays 0).
- Simultaneous start+stop in IDLE at cycle 5, stop at cycle 6 → res_cycles_o=1. A second start during RUN does not reset the count.
- Saturation: CNT_W=8, start, stop 300 cycles later → res_cycles_o=255, res_sat_o=1.
- Timeout (macro on):
  - budget_i=20, no stop → res_cycles_o=20, res_timeout_o=1, finish_req_o pulse 1 cycle.
  - Repeat with stop exactly on cycle 20 → res_timeout_o=0, no finish pulse.
  - Macro off, same stimulus → window stays in RUN and finish_req_o never rises.
- Reset mid-RUN after 7 cycles → all outputs 0 the next cycle. A subsequent start/stop 3 apart yields res_cycles_o=3.
